// File: rtl/rv_fifo_pkg.sv
// rtl/rv_fifo_pkg.sv - shared widths, pointer type and depth rules for rv_sync_fifo
package rv_fifo_pkg;

  localparam int unsigned MIN_DEPTH  = 2;
  localparam int unsigned MAX_ADDR_W = 16;

  // Index is sized for the largest supported FIFO; upper bits stay zero.
  typedef struct packed {
    logic                  wrap;
    logic [MAX_ADDR_W-1:0] idx;
  } fifo_ptr_t;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

  function automatic fifo_ptr_t ptr_inc(input fifo_ptr_t p, input int unsigned depth);
    fifo_ptr_t r;
    r = p;
    if (32'(p.idx) == depth - 1) begin
      r.idx  = '0;
      r.wrap = ~p.wrap;
    end else begin
      r.idx = p.idx + MAX_ADDR_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/ready_valid_if.sv
// rtl/ready_valid_if.sv - ready/valid stream link with sender and receiver views
interface ready_valid_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/rv_fifo_mem.sv
// rtl/rv_fifo_mem.sv - unreset storage array, one write port, one combinational read port
module rv_fifo_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_W     = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/rv_sync_fifo.sv
// rtl/rv_sync_fifo.sv - first-word fall-through ready/valid FIFO; RV_FIFO_WATERMARK_EN adds max_count
module rv_sync_fifo
  import rv_fifo_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned DEPTH      = 8,
  localparam int unsigned ADDR_W     = addr_width(DEPTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  ready_valid_if.slave       in_if,
  ready_valid_if.master      out_if,
`ifdef RV_FIFO_WATERMARK_EN
  output logic [ADDR_W:0]    max_count,
`endif
  output logic [ADDR_W:0]    count
);

  if (!is_pow2(DEPTH) || DEPTH < MIN_DEPTH || ADDR_W > MAX_ADDR_W) begin : g_bad_depth
    $error("rv_sync_fifo: DEPTH must be a power of 2 and at least 2");
  end

  fifo_ptr_t        wr_ptr_q, wr_ptr_d;
  fifo_ptr_t        rd_ptr_q, rd_ptr_d;
  logic             empty, full, push, pop;
  logic [ADDR_W:0]  wr_lin, rd_lin;

  // Full/empty come from registered pointers only, so ready/valid never see the far side.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q.wrap != rd_ptr_q.wrap) && (wr_ptr_q.idx == rd_ptr_q.idx);
    push     = in_if.valid && !full;
    pop      = out_if.ready && !empty;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q, DEPTH) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q, DEPTH) : rd_ptr_q;
    wr_lin   = {wr_ptr_q.wrap, wr_ptr_q.idx[ADDR_W-1:0]};
    rd_lin   = {rd_ptr_q.wrap, rd_ptr_q.idx[ADDR_W-1:0]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign in_if.ready  = !full;
  assign out_if.valid = !empty;
  assign count        = wr_lin - rd_lin;

`ifdef RV_FIFO_WATERMARK_EN
  logic [ADDR_W:0] count_d;
  logic [ADDR_W:0] max_count_q, max_count_d;

  always_comb begin
    count_d     = {wr_ptr_d.wrap, wr_ptr_d.idx[ADDR_W-1:0]} -
                  {rd_ptr_d.wrap, rd_ptr_d.idx[ADDR_W-1:0]};
    max_count_d = (count_d > max_count_q) ? count_d : max_count_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      max_count_q <= '0;
    end else begin
      max_count_q <= max_count_d;
    end
  end

  assign max_count = max_count_q;
`endif

  rv_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q.idx[ADDR_W-1:0]),
    .wdata (in_if.data),
    .raddr (rd_ptr_q.idx[ADDR_W-1:0]),
    .rdata (out_if.data)
  );

endmodule
